// File: rtl/lcm_lp_cmd_tx_if.sv
// Command-table / LP line bundle between the LP command transmitter and its
// surroundings (table ROM, start source, LP-to-HS switch stage).
interface lcm_lp_cmd_tx_if;
  logic        cfg_start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        lp_d0_p;
  logic        lp_d0_n;
  logic        busy;
  logic        lcm_cfg_done;

  modport master (
    input  cfg_start, rom_data,
    output rom_addr, lp_d0_p, lp_d0_n, busy, lcm_cfg_done
  );
  modport slave (
    output cfg_start, rom_data,
    input  rom_addr, lp_d0_p, lp_d0_n, busy, lcm_cfg_done
  );
endinterface

// File: rtl/lcm_lp_cmd_tx.sv
// Walks an init command table and sends its bytes over data lane 0 as LP
// escape-mode (LPDT) packets, with table-driven delays between packets.
module lcm_lp_cmd_tx #(
  parameter int LP_DIV     = 8,
  parameter int DELAY_UNIT = 50000
) (
  input  logic          clk,
  input  logic          rst,
  lcm_lp_cmd_tx_if.master bus
);
  localparam int DLY_MAX = 255 * DELAY_UNIT;
  localparam int DW = ($clog2(DLY_MAX + 1) > 25) ? $clog2(DLY_MAX + 1) : 25;
  localparam logic [7:0] CMD_BYTE = 8'hE1;
  localparam logic [7:0] DIV_LAST = 8'(LP_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, ESC_ENTRY, ENTRY_CMD, DATA, EXIT, GAP, DELAY, DONE
  } state_t;
  typedef enum logic [1:0] {PEND_NONE, PEND_DLY, PEND_END} pend_t;

  state_t        state;
  pend_t         pend;
  logic [7:0]    addr;
  logic [1:0]    typ;
  logic [7:0]    arg;
  logic          pkt_open, last;
  logic [3:0]    ph, ph_last;
  logic [7:0]    div;
  logic [DW-1:0] dly;
  logic [1:0]    line;
  logic          busy, done;
  logic          unused_bits;

  assign unused_bits = ^bus.rom_data[13:8];

  function automatic logic [1:0] bit_sym(logic b, logic half);
    return half ? 2'b00 : (b ? 2'b10 : 2'b01);
  endfunction

  // Line value {p,n} for a given symbol phase; each bit spans two phases.
  function automatic logic [1:0] lv(state_t s, logic [3:0] p, logic [7:0] a);
    case (s)
      ESC_ENTRY: case (p[1:0])
                   2'd0:    return 2'b10;
                   2'd2:    return 2'b01;
                   default: return 2'b00;
                 endcase
      ENTRY_CMD: return bit_sym(CMD_BYTE[3'd7 - p[3:1]], p[0]);
      DATA:      return bit_sym(a[p[3:1]], p[0]);
      EXIT:      return 2'b10;
      default:   return 2'b11;
    endcase
  endfunction

  always_comb begin
    ph_last = 4'd0;
    case (state)
      ESC_ENTRY:       ph_last = 4'd3;
      ENTRY_CMD, DATA: ph_last = 4'd15;
      default:         ph_last = 4'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE; pend <= PEND_NONE; addr <= '0; typ <= '0; arg <= '0;
      pkt_open <= 1'b0; last <= 1'b0; ph <= '0; div <= '0; dly <= '0;
      line <= 2'b11; busy <= 1'b0; done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.cfg_start) begin
          state <= FETCH; busy <= 1'b1; addr <= '0; last <= 1'b0;
        end
        // After the entry at 255 the table is exhausted: close and finish.
        FETCH: if (last) begin
          if (pkt_open) begin
            pend <= PEND_END; state <= EXIT; div <= '0; ph <= '0; line <= 2'b10;
          end else begin
            state <= DONE; busy <= 1'b0; done <= 1'b1;
          end
        end else begin
          typ <= bus.rom_data[15:14];
          arg <= bus.rom_data[7:0];
          last <= (addr == 8'hFF);
          if (addr != 8'hFF) addr <= addr + 8'd1;
          state <= DECODE;
        end
        DECODE: case (typ)
          2'b00, 2'b01: begin
            ph <= '0; div <= '0;
            if (pkt_open) begin
              state <= DATA; line <= lv(DATA, 4'd0, arg);
            end else begin
              pkt_open <= 1'b1; state <= ESC_ENTRY; line <= 2'b10;
            end
          end
          2'b10: if (pkt_open) begin
            pend <= PEND_DLY; state <= EXIT; div <= '0; ph <= '0; line <= 2'b10;
          end else begin
            state <= DELAY; dly <= DW'(arg) * DW'(DELAY_UNIT);
          end
          default: if (pkt_open) begin
            pend <= PEND_END; state <= EXIT; div <= '0; ph <= '0; line <= 2'b10;
          end else begin
            state <= DONE; busy <= 1'b0; done <= 1'b1;
          end
        endcase
        ESC_ENTRY, ENTRY_CMD, DATA, EXIT: begin
          if (div != DIV_LAST) div <= div + 8'd1;
          else begin
            div <= '0;
            if (ph != ph_last) begin
              ph <= ph + 4'd1; line <= lv(state, ph + 4'd1, arg);
            end else begin
              ph <= '0;
              case (state)
                ESC_ENTRY: begin state <= ENTRY_CMD; line <= lv(ENTRY_CMD, 4'd0, arg); end
                ENTRY_CMD: begin state <= DATA; line <= lv(DATA, 4'd0, arg); end
                // Between bytes the lane idles at LP-00 so the packet stays open.
                DATA: if (typ[0]) begin state <= EXIT; line <= 2'b10; end
                      else state <= FETCH;
                default: begin state <= GAP; pkt_open <= 1'b0; line <= 2'b11; end
              endcase
            end
          end
        end
        GAP: if (div != DIV_LAST) div <= div + 8'd1;
        else begin
          div <= '0; pend <= PEND_NONE;
          case (pend)
            PEND_DLY: begin state <= DELAY; dly <= DW'(arg) * DW'(DELAY_UNIT); end
            PEND_END: begin state <= DONE; busy <= 1'b0; done <= 1'b1; end
            default:  state <= FETCH;
          endcase
        end
        DELAY: if (dly <= DW'(1)) state <= FETCH;
               else dly <= dly - DW'(1);
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rom_addr     = addr;
  assign bus.lp_d0_p      = line[1];
  assign bus.lp_d0_n      = line[0];
  assign bus.busy         = busy;
  assign bus.lcm_cfg_done = done;
endmodule

// File: doc/lcm_lp_cmd_tx.md
LCM_LP_CMD_TX -- requirements
Module: lcm_lp_cmd_tx

Interface
REQ-001 Parameter LP_DIV, default 8: clk cycles per LP line state; legal range 1..255.
REQ-002 Parameter DELAY_UNIT, default 50000: clk cycles per delay count (1 ms at 50 MHz).
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cfg_start  input  1  one-cycle pulse that starts the init table walk.
REQ-006 rom_addr  output  8  command table address, registered.
REQ-007 rom_data  input  16  table entry from synchronous ROM, valid exactly 1 cycle after rom_addr changes.
REQ-008 lp_d0_p  output  1  LP-mode data lane 0 P line.
REQ-009 lp_d0_n  output  1  LP-mode data lane 0 N line.
REQ-010 busy  output  1  high from accepted cfg_start until lcm_cfg_done rises.
REQ-011 lcm_cfg_done  output  1  sticky level; high once the table is finished; consumed by the LP-to-HS clock switch stage.

Function
REQ-012 Entry format: [15:14] type, [7:0] arg; type 00 = data byte, 01 = last data byte of packet, 10 = delay of arg*DELAY_UNIT cycles, 11 = end of table.
REQ-013 States: IDLE, FETCH, DECODE, ESC_ENTRY, ENTRY_CMD, DATA, EXIT, GAP, DELAY, DONE.
REQ-014 IDLE: lines LP-11; on cfg_start go FETCH with rom_addr=0 and busy=1.
REQ-015 FETCH: hold rom_addr 1 cycle, sample rom_data into entry register, go DECODE; rom_addr increments by 1 after each sample.
REQ-016 DECODE, type 00/01 with no packet open: open packet, go ESC_ENTRY.
REQ-017 DECODE, type 00/01 with packet open: go DATA directly.
REQ-018 ESC_ENTRY: drive LP-10, LP-00, LP-01, LP-00 in order, each LP_DIV cycles, then ENTRY_CMD.
REQ-019 ENTRY_CMD: send 8'hE1 MSB first using the bit encoding of REQ-020, then DATA.
REQ-020 Bit encoding: bit 1 = LP-10 for LP_DIV cycles then LP-00 for LP_DIV cycles; bit 0 = LP-01 then LP-00, same timing.
REQ-021 DATA: send arg LSB first (16*LP_DIV cycles per byte); after type 00 go FETCH; after type 01 go EXIT.
REQ-022 EXIT: LP-10 for LP_DIV cycles, then LP-11; close packet; go GAP.
REQ-023 GAP: hold LP-11 for LP_DIV cycles, then FETCH (or the pending type 10/11 action of REQ-026).
REQ-024 DELAY: hold LP-11 for arg*DELAY_UNIT cycles, then FETCH; arg=0 gives zero wait (DELAY lasts 1 cycle).
REQ-025 Type 11: go DONE; lcm_cfg_done=1, busy=0, lines LP-11, held until reset.
REQ-026 Type 10/11 decoded with packet open: run EXIT and GAP first, then perform the delay/end.
REQ-027 After entry at address 255 is consumed with no type 11 seen: close any open packet per REQ-026, then DONE; rom_addr never wraps to 0.
REQ-028 cfg_start while busy or in DONE is ignored.
REQ-029 Delay counter is 8+17 bits wide minimum, no overflow for arg=255 at default DELAY_UNIT.
REQ-030 Line outputs are registered; no glitches on state transitions.

Reset
REQ-031 rst=1 at any time: state IDLE, lp_d0_p=1, lp_d0_n=1, rom_addr=0, busy=0, lcm_cfg_done=0, all counters 0, packet flag cleared.
REQ-032 Reset mid-packet aborts immediately without an exit sequence; lines go LP-11 asynchronously.

Verification
REQ-033 LP_DIV=2, table {0x4011, 0xC000}, pulse cfg_start -> line sequence 11,10,00,01,00, E1 MSB-first, 0x11 LSB-first (1,0,0,0,1,0,0,0), 10,11; lcm_cfg_done rises after 66+ cycles; busy falls same cycle.
REQ-034 Table {0x0029, 0x4000, 0x8002, 0xC000}, DELAY_UNIT=10 -> one packet of 2 bytes (single entry/exit), then 20 cycles LP-11, then done.
REQ-035 Table {0x0005, 0xC000} (type 11 while packet open) -> exit sequence 10,11 emitted before lcm_cfg_done rises.
REQ-036 cfg_start pulsed again mid-packet and after done -> no change in rom_addr, lines or done.
REQ-037 rst asserted during DATA bit 3 -> lines 11 and all outputs at reset values same cycle; new cfg_start restarts from address 0.
REQ-038 Table of 256 type-00 entries -> after address 255 exit sequence sent, lcm_cfg_done=1, rom_addr stays 255.
